// File: rtl/ps2_key_receiver.sv
// ---------------------------------------------------------------------------
// ps2_key_receiver
//
// Purpose:
//   Deframes the PS/2 keyboard line into scan-code bytes. It folds the E0
//   (extended) and F0 (break) prefixes into single key events and queues
//   those events in a small FIFO. The CPU keyboard input port pops that FIFO.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   key_clk    in   PS/2 clock (asynchronous, idle high)
//   key_data   in   PS/2 data  (asynchronous, idle high)
//   out_data   out  {extended, released, code[7:0]} at FIFO head, 0 when empty
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts head
//   frame_err  out  one-cycle pulse when a frame is rejected or times out
//   overflow   out  sticky: an event was dropped because the FIFO was full
//
// Handshake: the head entry transfers on any rising clk edge where
//   out_valid & out_ready are both high. out_data is stable while out_valid
//   is high and out_ready is low. out_valid does not depend on out_ready.
// ---------------------------------------------------------------------------
module ps2_key_receiver #(
   parameter int TIMEOUT    = 50000,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_clk,
   input  logic       key_data,
   output logic [9:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_err,
   output logic       overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Synchronizers and falling-edge detect
   // ------------------------------------------------------------------
   logic kclk_s1_q, kclk_s1_d;
   logic kclk_s2_q, kclk_s2_d;
   logic kclk_prev_q, kclk_prev_d;
   logic kdat_s1_q, kdat_s1_d;
   logic kdat_s2_q, kdat_s2_d;
   logic fall;

   always_comb begin
      kclk_s1_d   = key_clk;
      kclk_s2_d   = kclk_s1_q;
      kclk_prev_d = kclk_s2_q;
      kdat_s1_d   = key_data;
      kdat_s2_d   = kdat_s1_q;
   end

   // Data is sampled in the same cycle the synced clock is seen falling.
   assign fall = kclk_prev_q & ~kclk_s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         kclk_s1_q   <= 1'b1;
         kclk_s2_q   <= 1'b1;
         kclk_prev_q <= 1'b1;
         kdat_s1_q   <= 1'b1;
         kdat_s2_q   <= 1'b1;
      end else begin
         kclk_s1_q   <= kclk_s1_d;
         kclk_s2_q   <= kclk_s2_d;
         kclk_prev_q <= kclk_prev_d;
         kdat_s1_q   <= kdat_s1_d;
         kdat_s2_q   <= kdat_s2_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_vld_q, byte_vld_d;
   logic [7:0]    byte_q, byte_d;
   logic          frame_err_q, frame_err_d;

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      byte_vld_d  = 1'b0;
      byte_d      = byte_q;
      frame_err_d = 1'b0;

      // The watchdog only runs while a frame is in progress. Any clock edge
      // proves the sender is still alive.
      if ((state_q == S_IDLE) || fall) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            // A falling edge with data high is not a start bit. Ignore it.
            if (fall && !kdat_s2_q) begin
               state_d  = S_DATA;
               bitcnt_d = 3'd0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d  = {kdat_s2_q, shift_q[7:1]};   // LSB first
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fall) begin
               parity_d = kdat_s2_q;
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               // Odd parity: data plus parity bit must hold an odd number of ones.
               if (kdat_s2_q && (^{shift_q, parity_q})) begin
                  byte_vld_d = 1'b1;
                  byte_d     = shift_q;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort a stalled frame. The partial byte is dropped. Prefix flags
      // live in the decoder and are left untouched.
      if ((state_q != S_IDLE) && !fall && (tmo_q >= TW'(TIMEOUT - 1))) begin
         state_d     = S_IDLE;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bitcnt_q    <= 3'd0;
         shift_q     <= 8'd0;
         parity_q    <= 1'b0;
         tmo_q       <= '0;
         byte_vld_q  <= 1'b0;
         byte_q      <= 8'd0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
         byte_vld_q  <= byte_vld_d;
         byte_q      <= byte_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;

   // ------------------------------------------------------------------
   // Prefix decoder: E0/F0 only set flags. Any other byte becomes an event.
   // ------------------------------------------------------------------
   logic       ext_q, ext_d;
   logic       rel_q, rel_d;
   logic       push_req;
   logic [9:0] push_data;

   always_comb begin
      ext_d     = ext_q;
      rel_d     = rel_q;
      push_req  = 1'b0;
      push_data = {ext_q, rel_q, byte_q};
      if (byte_vld_q) begin
         if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (byte_q == 8'hF0) begin
            rel_d = 1'b1;
         end else begin
            // Flags are consumed even if the FIFO then drops the event.
            push_req = 1'b1;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ext_q <= 1'b0;
         rel_q <= 1'b0;
      end else begin
         ext_q <= ext_d;
         rel_q <= rel_d;
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------
   logic [9:0]            mem_q [DEPTH];
   logic [9:0]            mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  full;
   logic                  do_pop;
   logic                  do_push;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = (count_q != '0) && out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push_req && (!full || do_pop);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (push_req & ~do_push);

      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset. The empty case forces the output to zero instead.
   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : 10'd0;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_receiver
//
// Bench for ps2_key_receiver. A PS/2 frame driver plays the keyboard. A
// key-event model at the level of the protocol rules builds the expected
// event queue, and a negedge monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_ps2_key_receiver;

   localparam int TMO   = 100;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_clk;
   logic       key_data;
   logic [9:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;
   logic       overflow;

   ps2_key_receiver #(.TIMEOUT(TMO), .DEPTH_LOG2(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_clk   (key_clk),
      .key_data  (key_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   // Clock/reset block: 14 ns period.
   always #7 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state
   logic [9:0] exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   err_cnt = 0;
   int   exp_err = 0;
   int   err_cyc = 0;
   int   last_fall_cyc = 0;
   logic err_prev = 1'b0;
   logic exp_ovf = 1'b0;
   logic m_ext = 1'b0;
   logic m_rel = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected queue on every accepted transfer and checks
   // that frame_err pulses are exactly one cycle wide.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pop_unexpected: got=%0h expected=none", out_data);
            end else begin
               check("pop_data", {22'd0, out_data}, {22'd0, exp_q.pop_front()});
            end
         end
         if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
            if (err_prev) check("err_width", 32'd2, 32'd1);
         end
         err_prev = frame_err;
      end
   end

   // Model of the key-event rules for one correctly received byte.
   task automatic model_accept(input logic [7:0] b);
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_rel = 1'b1;
      end else begin
         if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
         else exp_q.push_back({m_ext, m_rel, b});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_ovf = 1'b0;
      m_ext   = 1'b0;
      m_rel   = 1'b0;
   endtask

   // Driver tasks. Entry and exit are at posedge+1; one bit takes 8 cycles.
   task automatic drive_bit(input logic b, input logic pop_now);
      key_data = b;
      repeat (4) @(posedge clk);
      #1 key_clk = 1'b0;
      last_fall_cyc = cyc;
      if (pop_now) begin
         // The push from this stop edge lands on the 4th rising edge. Pop in
         // that same cycle.
         repeat (3) @(posedge clk);
         #1 out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end else begin
         repeat (4) @(posedge clk);
         #1;
      end
      key_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_at_stop);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) drive_bit(fr[i], pop_at_stop && (i == 10));
      key_data = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      if (bad_par) exp_err++;
      else model_accept(b);
   endtask

   task automatic check_head(input string name);
      check({name, "_valid"}, {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check({name, "_data"}, {22'd0, out_data}, {22'd0, exp_q[0]});
      else check({name, "_empty_data"}, {22'd0, out_data}, 32'd0);
   endtask

   task automatic check_status(input string name);
      check({name, "_errs"}, err_cnt, exp_err);
      check({name, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      while (n < 50) begin
         @(negedge clk);
         if (!out_valid) break;
         n++;
      end
      if (n >= 50) check("drain_bound", n, 0);
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("drain_left", exp_q.size(), 0);
      check("drain_data0", {22'd0, out_data}, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // Watchdog
   initial begin
      #5ms;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      key_clk = 1'b1;
      key_data = 1'b1;
      out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", {22'd0, out_data}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);

      // Plain make code
      send_frame(8'h14, 1'b0, 1'b0);
      check_head("t1");
      check_status("t1");
      drain();

      // Break prefix, then a flag-free follower
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h14, 1'b0, 1'b0);
      check_head("t2");
      check("t2_depth", exp_q.size(), 1);
      send_frame(8'h1C, 1'b0, 1'b0);
      drain();

      // Extended break, then a single-cycle pop
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      check_head("t3");
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check_head("t3_pop");

      // Parity error, then recovery
      send_frame(8'h14, 1'b1, 1'b0);
      check_status("par");
      check_head("par");
      send_frame(8'h1C, 1'b0, 1'b0);
      check_head("par_next");
      drain();

      // Timeout: start bit plus 4 data bits, then silence
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) drive_bit((i == 0) ? 1'b0 : logic'(i[0]), 1'b0);
      key_data = 1'b1;
      repeat (130) @(posedge clk);
      #1;
      exp_err++;
      check_status("tmo");
      check("tmo_delay_lo", {31'd0, (err_cyc - last_fall_cyc) >= 99}, 32'd1);
      check("tmo_delay_hi", {31'd0, (err_cyc - last_fall_cyc) <= 105}, 32'd1);
      send_frame(8'h29, 1'b0, 1'b0);
      check_head("tmo_next");
      drain();

      // key_clk stuck low mid-frame: exactly one timeout
      @(posedge clk);
      #1 key_data = 1'b0;
      key_clk = 1'b0;
      repeat (350) @(posedge clk);
      #1 key_clk = 1'b1;
      key_data = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      exp_err++;
      check_status("stuck");
      send_frame(8'h5A, 1'b0, 1'b0);
      check_head("stuck_next");
      drain();

      // Randomized traffic
      for (int k = 0; k < 24; k++) begin
         logic [7:0] b;
         int sel;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 8'hE0;
         else if (sel == 1) b = 8'hF0;
         else b = 8'($urandom_range(0, 255));
         send_frame(b, $urandom_range(0, 5) == 0, 1'b0);
         if ($urandom_range(0, 2) == 0) drain();
      end
      drain();
      check_status("rand");

      // Overflow and push/pop while full
      do_reset();
      check("ovf_rst", {31'd0, overflow}, 32'd0);
      for (int v = 8'h15; v <= 8'h19; v++) send_frame(8'(v), 1'b0, 1'b0);
      check_status("ovf");
      check_head("ovf_head");
      send_frame(8'h1A, 1'b0, 1'b1);
      check("ovf_full_depth", exp_q.size(), DEPTH);
      check_head("ovf_pp");
      check_status("ovf_pp");
      drain();

      // Reset in the middle of a frame
      do_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
      key_data = 1'b1;
      do_reset();
      repeat (200) @(posedge clk);
      #1;
      check_status("mid_rst");
      check_head("mid_rst");
      send_frame(8'h14, 1'b0, 1'b0);
      check_head("mid_rst_next");
      drain();
      check_status("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
